// File: rtl/rra_pkg.sv
// Shared types and constants for the round-robin arbiter requester client.
// Holds the channel count, the FSM state encoding and the pending-counter saturation helper.
package rra_pkg;

    localparam int NUM_CH    = 4;
    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2,
        REL  = 2'd3
    } rra_cli_st_t;

    // Pending counter sticks at its all-ones value; further jobs are dropped.
    localparam int PEND_SAT_DEF = (1 << CNT_W_DEF) - 1;

    function automatic int pend_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/rra_req_chan.sv
// One requester channel: pending-job counter, REQ/OWN/REL FSM, burst counter, sticky overflow.
// Latency: job edge k -> req high after edge k+1; BURST granted cycles per job, then one release cycle.
// Backpressure: jobs queue in a saturating counter; a job arriving while full is dropped and flags ovf.
module rra_req_chan
    import rra_pkg::*;
#(
    parameter int BURST = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_job,
    input  logic i_gnt,
    output logic o_req,
    output logic o_done,
    output logic o_busy,
    output logic o_ovf
);

    localparam int                BW    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0]     BLOAD = BW'(BURST - 1);
    localparam logic [CNT_W-1:0]  PMAX  = CNT_W'(pend_max(CNT_W));

    rra_cli_st_t      r_st;
    logic [CNT_W-1:0] r_pend;
    logic [BW-1:0]    r_cnt;
    logic             r_req;
    logic             r_done;
    logic             r_busy;
    logic             r_ovf;

    logic w_dec;
    logic w_full;

    // A job is consumed only at the moment the grant is accepted.
    assign w_dec  = (r_st == REQ) && i_gnt;
    assign w_full = (r_pend == PMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st   <= IDLE;
            r_pend <= '0;
            r_cnt  <= '0;
            r_req  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_job && !w_dec) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_pend <= r_pend + 1'b1;
                end
            end else if (w_dec && !i_job) begin
                r_pend <= r_pend - 1'b1;
            end

            r_done <= 1'b0;
            case (r_st)
                IDLE: begin
                    if (r_pend != '0) begin
                        r_st  <= REQ;
                        r_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (i_gnt) begin
                        r_st   <= OWN;
                        r_cnt  <= BLOAD;
                        r_busy <= 1'b1;
                    end
                end
                OWN: begin
                    // A missing grant stalls the tenure without giving up the request.
                    if (i_gnt) begin
                        if (r_cnt == '0) begin
                            r_st   <= REL;
                            r_req  <= 1'b0;
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                REL: begin
                    r_st <= IDLE;
                end
                default: begin
                    r_st   <= IDLE;
                    r_req  <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_req  = r_req;
    assign o_done = r_done;
    assign o_busy = r_busy;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/rra_req_client.sv
// Four-channel requester agent for the rra arbiter; optional grant checker under RRA_GNT_CHECK_EN.
// Latency: req registered, 2 cycles from job pulse; done pulses one cycle after the last granted cycle.
// Backpressure: per-channel saturating job queue; grants outside REQ/OWN are ignored by the channels.
module rra_req_client
    import rra_pkg::*;
#(
    parameter int BURST = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  job_in,
    input  logic        gnt3,
    input  logic        gnt2,
    input  logic        gnt1,
    input  logic        gnt0,
    output logic        req3,
    output logic        req2,
    output logic        req1,
    output logic        req0,
    output logic [3:0]  done,
    output logic [3:0]  busy,
    output logic [3:0]  ovf,
    output logic        gnt_err
);

    logic [NUM_CH-1:0] w_gnt;
    logic [NUM_CH-1:0] w_req;

    assign w_gnt = {gnt3, gnt2, gnt1, gnt0};

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        rra_req_chan #(
            .BURST (BURST),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_job  (job_in[n]),
            .i_gnt  (w_gnt[n]),
            .o_req  (w_req[n]),
            .o_done (done[n]),
            .o_busy (busy[n]),
            .o_ovf  (ovf[n])
        );
    end

    assign req0 = w_req[0];
    assign req1 = w_req[1];
    assign req2 = w_req[2];
    assign req3 = w_req[3];

`ifdef RRA_GNT_CHECK_EN
    logic w_multi;
    logic w_stray;
    logic r_gnt_err;

    // req is low exactly in IDLE and REL, so a grant against a low req is a stray grant.
    assign w_multi = (w_gnt & (w_gnt - 4'd1)) != 4'd0;
    assign w_stray = (w_gnt & ~w_req) != 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_err <= 1'b0;
        end else if (w_multi || w_stray) begin
            r_gnt_err <= 1'b1;
        end
    end

    assign gnt_err = r_gnt_err;
`else
    assign gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_rra_req_client.sv
// Directed plus randomized bench for rra_req_client against a cycle-level job/tenure model.
module tb_rra_req_client;

    localparam int BURST = 2;
    localparam int CNT_W = 3;
    localparam int PMAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] job_in;
    logic [3:0] gnt;
    logic       req3, req2, req1, req0;
    logic [3:0] done, busy, ovf;
    logic       gnt_err;

    always #5 clk = ~clk;

    rra_req_client #(.BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .job_in  (job_in),
        .gnt3    (gnt[3]),
        .gnt2    (gnt[2]),
        .gnt1    (gnt[1]),
        .gnt0    (gnt[0]),
        .req3    (req3),
        .req2    (req2),
        .req1    (req1),
        .req0    (req0),
        .done    (done),
        .busy    (busy),
        .ovf     (ovf),
        .gnt_err (gnt_err)
    );

    int checks   = 0;
    int failures = 0;

    // Model: jobs waiting, whether a request is up, whether the bus is held,
    // grants still owed for the tenure, and a one-cycle cool-down after completion.
    int       m_pend [4];
    int       m_left [4];
    bit [3:0] m_req, m_own, m_cool, m_done, m_ovf;
    bit       m_err;

    int owner, last_gnt;

    function automatic logic [3:0] dut_req();
        return {req3, req2, req1, req0};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_pend[n] = 0;
            m_left[n] = 0;
        end
        m_req = '0; m_own = '0; m_cool = '0; m_done = '0; m_ovf = '0; m_err = 1'b0;
        owner = -1;
        last_gnt = 3;
    endtask

    task automatic model_step(input logic [3:0] job, input logic [3:0] g, input logic r);
        if (r) begin
            model_reset();
            return;
        end
`ifdef RRA_GNT_CHECK_EN
        if ($countones(g) > 1 || (g & ~m_req) != 4'd0) m_err = 1'b1;
`endif
        for (int n = 0; n < 4; n++) begin
            int  p;
            bit  take;
            p    = m_pend[n];
            take = m_req[n] && !m_own[n] && g[n];
            if (job[n] && !take) begin
                if (p == PMAX) m_ovf[n] = 1'b1;
                else           m_pend[n] = p + 1;
            end else if (take && !job[n]) begin
                m_pend[n] = p - 1;
            end
            m_done[n] = 1'b0;
            if (m_cool[n]) begin
                m_cool[n] = 1'b0;
            end else if (!m_req[n]) begin
                if (p > 0) m_req[n] = 1'b1;
            end else if (!m_own[n]) begin
                if (g[n]) begin
                    m_own[n]  = 1'b1;
                    m_left[n] = BURST;
                end
            end else if (g[n]) begin
                m_left[n] = m_left[n] - 1;
                if (m_left[n] == 0) begin
                    m_own[n]  = 1'b0;
                    m_req[n]  = 1'b0;
                    m_done[n] = 1'b1;
                    m_cool[n] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] job, input logic [3:0] g);
        job_in = job;
        gnt    = g;
        model_step(job, g, rst);
        @(posedge clk);
        #1;
        check("req",     {28'd0, dut_req()}, {28'd0, m_req});
        check("done",    {28'd0, done},      {28'd0, m_done});
        check("busy",    {28'd0, busy},      {28'd0, m_own});
        check("ovf",     {28'd0, ovf},       {28'd0, m_ovf});
        check("gnt_err", {31'd0, gnt_err},   {31'd0, m_err});
    endtask

    // Round-robin arbiter stand-in: holds the grant until the owner drops req.
    task automatic arb(input bit gaps, output logic [3:0] g);
        if (owner >= 0 && !m_req[owner]) owner = -1;
        if (owner < 0) begin
            for (int i = 1; i <= 4; i++) begin
                int c;
                c = (last_gnt + i) % 4;
                if (m_req[c] && owner < 0) begin
                    owner    = c;
                    last_gnt = c;
                end
            end
        end
        g = (owner >= 0) ? (4'd1 << owner) : 4'd0;
        if (gaps && $urandom_range(7) == 0) g = 4'd0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick(4'd0, 4'd0);
        rst = 1'b0;
    endtask

    int         first_req, busy_cnt, done_cnt, done0, done1, done2, t0, t1, viol;
    logic       prev_req0, req_at_done;
    logic [3:0] g;

    initial begin
        rst    = 1'b1;
        job_in = '0;
        gnt    = '0;
        model_reset();

        // Reset and idle outputs
        do_reset(5);
        check("rst_req",  {28'd0, dut_req()}, 32'd0);
        check("rst_busy", {28'd0, busy},      32'd0);

        // Single job on ch0, grant follows req0 one cycle late
        tick(4'b0001, 4'd0);
        first_req = -1; busy_cnt = 0; done_cnt = 0; prev_req0 = 1'b0; req_at_done = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            logic pr;
            pr = prev_req0;
            prev_req0 = req0;
            tick(4'd0, {3'd0, pr});
            if (req0 && first_req < 0) first_req = i;
            if (busy[0]) busy_cnt++;
            if (done[0]) begin
                done_cnt++;
                req_at_done = req0;
            end
        end
        check("lat_req0",    first_req,             32'd1);
        check("busy0_len",   busy_cnt,              BURST);
        check("done0_once",  done_cnt,              32'd1);
        check("req_at_done", {31'd0, req_at_done},  32'd0);
        check("req0_final",  {31'd0, req0},         32'd0);

        // Two simultaneous jobs served in turn
        do_reset(1);
        tick(4'b0011, 4'd0);
        done0 = 0; done1 = 0; t0 = -1; t1 = -1; viol = 0;
        for (int i = 0; i < 20; i++) begin
            arb(1'b0, g);
            tick(4'd0, g);
            if (busy[0] && !req1) viol++;
            if (done[0]) begin done0++; t0 = i; end
            if (done[1]) begin done1++; t1 = i; end
        end
        check("two_done0",  done0, 32'd1);
        check("two_done1",  done1, 32'd1);
        check("two_order",  {31'd0, t0 >= 0 && t0 < t1}, 32'd1);
        check("req1_hold",  viol, 32'd0);

        // Pending saturation on ch2
        do_reset(1);
        for (int i = 0; i < 8; i++) tick(4'b0100, 4'd0);
        check("sat_ovf2", {31'd0, ovf[2]}, 32'd1);
        done2 = 0;
        for (int i = 0; i < 60; i++) begin
            arb(1'b0, g);
            tick(4'd0, g);
            if (done[2]) done2++;
        end
        check("sat_tenures", done2, PMAX);
        check("sat_req2",    {31'd0, req2}, 32'd0);

        // Job arriving on the REQ->OWN edge keeps pend at 1
        do_reset(1);
        tick(4'b0001, 4'd0);
        tick(4'd0, 4'd0);
        tick(4'b0001, 4'b0001);
        done0 = 0;
        for (int i = 0; i < 20; i++) begin
            arb(1'b0, g);
            tick(4'd0, g);
            if (done[0]) done0++;
        end
        check("same_cyc_done", done0, 32'd2);
        check("same_cyc_ovf",  {31'd0, ovf[0]}, 32'd0);

        // Illegal grant patterns
        do_reset(1);
        tick(4'd0, 4'b0011);
        tick(4'd0, 4'b1000);
        tick(4'd0, 4'd0);
`ifdef RRA_GNT_CHECK_EN
        check("gnt_err_on",  {31'd0, gnt_err}, 32'd1);
`else
        check("gnt_err_off", {31'd0, gnt_err}, 32'd0);
`endif
        check("stray_req",  {28'd0, dut_req()}, 32'd0);
        check("stray_busy", {28'd0, busy},      32'd0);

        // Randomized traffic with grant gaps, junk grants and occasional resets
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] j;
            for (int n = 0; n < 4; n++) j[n] = ($urandom_range(5) == 0);
            arb(1'b1, g);
            if ($urandom_range(49) == 0) g = 4'($urandom_range(15));
            if ($urandom_range(499) == 0) rst = 1'b1;
            tick(j, g);
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
